inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 64 ++++++
 tb/tb_inst_fetch.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: sequential fetch unit feeding a 2-entry {inst, pc} queue to decode,
// with redirect, sticky misaligned-redirect halt and asynchronous reset.
module inst_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        done_load_inst,
   output logic [63:0] out_inst_addr,
   input  logic [31:0] in_inst,
   input  logic        redirect_en,
   input  logic [63:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_out,
   output logic [63:0] inst_pc,
   output logic        misalign_err
);
   typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
   state_t      state, state_nxt;
   logic [63:0] fetch_pc;
   logic [1:0]  cnt, wr;
   logic [95:0] e0, e1;
   logic        redir, mis, pop, push;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      if (mis) state_nxt = HALT;
      else if (state == IDLE && done_load_inst) state_nxt = FETCH;
   end
   // HALT ignores redirects entirely; a misaligned target never reaches fetch_pc
   always_comb begin
      redir = redirect_en && state != HALT;
      mis   = redir && redirect_pc[1:0] != 2'b00;
      pop   = inst_valid && inst_ready;
      push  = state == FETCH && !redirect_en && (cnt != 2'd2 || pop);
      wr    = cnt - {1'b0, pop};
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc     <= RESET_PC;
         cnt          <= '0;
         e0           <= '0;
         e1           <= '0;
         misalign_err <= 1'b0;
      end else begin
         cnt <= redir ? 2'd0 : cnt + {1'b0, push} - {1'b0, pop};
         if (redir && !mis) fetch_pc <= redirect_pc;
         else if (push)     fetch_pc <= fetch_pc + 64'd4;
         if (mis) misalign_err <= 1'b1;
         // shift on pop, then the new entry lands in the first free slot
         if (pop) e0 <= e1;
         if (push && wr == 2'd0) e0 <= {in_inst, fetch_pc};
         if (push && wr == 2'd1) e1 <= {in_inst, fetch_pc};
      end
   end
   assign out_inst_addr = fetch_pc;
   assign inst_valid    = cnt != 2'd0;
   assign inst_out      = inst_valid ? e0[95:64] : 32'h0;
   assign inst_pc       = inst_valid ? e0[63:0] : 64'h0;
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_inst_fetch;
   localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;
   logic        clk = 0, rst = 1, done = 0, ready = 0, ren = 0;
   logic [63:0] rpc = 0;
   logic [63:0] addr, pc;
   logic [31:0] inst;
   logic        valid, err;
   logic [63:0] addr_w, pc_w;
   logic [31:0] inst_w;
   logic        valid_w, err_w;
   int checks = 0, failures = 0;
   int          m_state;
   logic [63:0] m_pc;
   logic [63:0] m_q[$];
   logic        m_err;
   logic [63:0] a0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [63:0] a);
      return a == 64'h0 ? 32'h00000013 : a == 64'h4 ? 32'h00100093 : (a[31:0] * 32'h9E3779B1) ^ a[63:32];
   endfunction

   inst_fetch dut (.clk(clk), .rst(rst), .done_load_inst(done), .out_inst_addr(addr), .in_inst(mem(addr)),
      .redirect_en(ren), .redirect_pc(rpc), .inst_valid(valid), .inst_ready(ready), .inst_out(inst),
      .inst_pc(pc), .misalign_err(err));

   inst_fetch #(.RESET_PC(WRAP_PC)) dut_w (.clk(clk), .rst(rst), .done_load_inst(1'b1), .out_inst_addr(addr_w),
      .in_inst(mem(addr_w)), .redirect_en(1'b0), .redirect_pc(64'h0), .inst_valid(valid_w), .inst_ready(1'b1),
      .inst_out(inst_w), .inst_pc(pc_w), .misalign_err(err_w));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_pc    = 64'h0;
      m_q.delete();
      m_err   = 1'b0;
   endtask

   // model: 0=idle 1=fetch 2=halt; queue holds fetched pcs in order
   always @(posedge clk) if (!rst) begin
      if (m_state != 2 && ren) begin
         if (rpc[1:0] != 2'b00) begin
            m_state = 2;
            m_err   = 1'b1;
         end else m_pc = rpc;
         m_q.delete();
      end else begin
         if (m_q.size() > 0 && ready) void'(m_q.pop_front());
         if (m_state == 1 && m_q.size() < 2) begin
            m_q.push_back(m_pc);
            m_pc = m_pc + 64'd4;
         end
      end
      if (m_state == 0 && done) m_state = 1;
   end

   task automatic compare();
      chk("valid", valid, m_q.size() > 0);
      chk("addr", addr, m_pc);
      chk("err", err, m_err);
      chk("pc", pc, m_q.size() > 0 ? m_q[0] : 64'h0);
      chk("inst", inst, m_q.size() > 0 ? mem(m_q[0]) : 32'h0);
   endtask

   task automatic cyc(input logic d, input logic r, input logic e, input logic [63:0] p);
      done = d; ready = r; ren = e; rpc = p;
      @(negedge clk);
      compare();
   endtask

   task automatic do_reset();
      rst = 1;
      #1;
      chk("rst_valid", valid, 0);
      chk("rst_addr", addr, 64'h0);
      chk("rst_err", err, 0);
      model_reset();
      @(negedge clk);
      rst = 0;
   endtask

   task automatic fill_two();
      do_reset();
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      rst = 0;
      // wrap instance: FETCH after first edge, pushes FFF8, FFFC, 0
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      chk("wrap_pc0", pc_w, WRAP_PC);
      cyc(0, 1, 0, 0);
      chk("wrap_pc1", pc_w, 64'hFFFF_FFFF_FFFF_FFFC);
      cyc(0, 1, 0, 0);
      chk("wrap_pc2", pc_w, 64'h0);
      chk("wrap_valid", valid_w, 1);
      // start-up
      for (int i = 0; i < 5; i++) begin
         cyc(0, 1, 0, 0);
         chk("start_idle", valid, 0);
      end
      cyc(1, 1, 0, 0);
      chk("start_n", valid, 0);
      cyc(0, 1, 0, 0);
      chk("start_pc0", pc, 64'h0);
      chk("start_inst0", inst, 32'h00000013);
      cyc(0, 1, 0, 0);
      chk("start_pc1", pc, 64'h4);
      chk("start_inst1", inst, 32'h00100093);
      // backpressure
      fill_two();
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
      chk("bp_addr", addr, 64'h8);
      chk("bp_pc", pc, 64'h0);
      cyc(0, 1, 0, 0);
      chk("bp_rel0", pc, 64'h4);
      cyc(0, 1, 0, 0);
      chk("bp_rel1", pc, 64'h8);
      // redirect with full queue and a coinciding pop
      fill_two();
      cyc(0, 1, 1, 64'h100);
      chk("redir_flush", valid, 0);
      cyc(0, 1, 0, 0);
      chk("redir_pc0", pc, 64'h100);
      cyc(0, 1, 0, 0);
      chk("redir_pc1", pc, 64'h104);
      // misaligned redirect halts until reset
      a0 = addr;
      cyc(0, 1, 1, 64'h102);
      chk("mis_err", err, 1);
      chk("mis_valid", valid, 0);
      chk("mis_addr", addr, a0);
      for (int i = 0; i < 4; i++) cyc(1, 1, i[0], 64'h200);
      chk("mis_hold_addr", addr, a0);
      chk("mis_hold_err", err, 1);
      // asynchronous reset with a full queue, mid-cycle
      fill_two();
      chk("async_pre", valid, 1);
      do_reset();
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [63:0] t;
         int k;
         k = $urandom_range(0, 199);
         if (k == 0) do_reset();
         else begin
            t = {$urandom, $urandom};
            if (k < 3) t[1:0] = 2'($urandom_range(1, 3));
            else t[1:0] = 2'b00;
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7, k < 12, t);
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
